// File: rtl/time_tmr_rr_scheduler.sv
// Round-robin issue arbiter in front of a time-redundant datapath, with an in-order
// routing FIFO that steers each voted result back to the requester that issued it.
module time_tmr_rr_scheduler #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int Depth     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [DataWidth-1:0]          dp_data_o,
    output logic                          dp_valid_o,
    input  logic                          dp_ready_i,
    input  logic [DataWidth-1:0]          dp_data_i,
    input  logic                          dp_valid_i,
    output logic                          dp_ready_o,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [$clog2(Depth+1)-1:0]    outstanding_o,
    output logic                          unexpected_o
);

    // state     | meaning
    // ST_OPEN   | grant follows the round-robin search every cycle
    // ST_LOCKED | offer stalled by the datapath; stored grant held until handshake

    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    localparam logic [IdxW:0]   NumReqW  = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastReq  = IdxW'(NumReq - 1);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthW   = CntW'(Depth);

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t               state_q, state_d;
    logic [IdxW-1:0]      rr_ptr_q;
    logic [IdxW-1:0]      lock_idx_q;
    logic [IdxW-1:0]      fifo_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic [DataWidth-1:0] req_data_arr [NumReq];
    logic [IdxW-1:0]      rr_idx;
    logic [IdxW-1:0]      grant;
    logic [IdxW-1:0]      head;
    logic                 full, empty, push, pop;

    for (genvar r = 0; r < NumReq; r++) begin : g_unpack
        assign req_data_arr[r] = req_data_i[r*DataWidth +: DataWidth];
    end

    // First valid requester at or above the pointer, wrapping past NumReq-1.
    always_comb begin
        logic [IdxW:0] cand;
        logic          found;
        rr_idx = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (cand >= NumReqW) cand = cand - NumReqW;
            if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                found  = 1'b1;
                rr_idx = cand[IdxW-1:0];
            end
        end
    end

    assign full  = (count_q == DepthW);
    assign empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        if (state_q == ST_LOCKED) begin
            grant      = lock_idx_q;
            dp_valid_o = 1'b1;
        end else begin
            grant      = rr_idx;
            dp_valid_o = (|req_valid_i) && !full;
        end
        dp_data_o = req_data_arr[grant];
        push      = dp_valid_o && dp_ready_i;
        if (push) begin
            req_ready_o[grant] = 1'b1;
            state_d            = ST_OPEN;
        end else if (dp_valid_o) begin
            state_d = ST_LOCKED;
        end
    end

    always_comb begin
        head        = fifo_q[rd_ptr_q];
        rsp_valid_o = '0;
        if (dp_valid_i && !empty) rsp_valid_o[head] = 1'b1;
        dp_ready_o   = !empty && rsp_ready_i[head];
        pop          = dp_valid_i && dp_ready_o;
        unexpected_o = dp_valid_i && empty;
    end

    assign rsp_data_o    = dp_data_i;
    assign outstanding_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_OPEN;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                rr_ptr_q <= (grant == LastReq) ? '0 : grant + 1'b1;
            end else if (state_q == ST_OPEN && dp_valid_o) begin
                lock_idx_q <= rr_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= grant;
                wr_ptr_q         <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
